// File: rtl/cic_decimator_mc_if.sv
// AXI-stream style sample bus for the multi-channel CIC decimator:
// one input stream, and one output stream tagged with its channel index.
interface cic_decimator_mc_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CW        = 1
);
    logic [WIDTH-1:0]     input_tdata;
    logic                 input_tvalid;
    logic                 input_tready;
    logic [OUT_WIDTH-1:0] output_tdata;
    logic [CW-1:0]        output_tchan;
    logic                 output_tvalid;
    logic                 output_tready;

    modport master (
        output input_tdata, input_tvalid, output_tready,
        input  input_tready, output_tdata, output_tchan, output_tvalid
    );

    modport slave (
        input  input_tdata, input_tvalid, output_tready,
        output input_tready, output_tdata, output_tchan, output_tvalid
    );
endinterface

// File: rtl/cic_decimator_mc.sv
// Time-interleaved CIC decimator: per-channel integrator/comb state, round-robin
// channel order, per-group rate/shift latching and a saturating registered output.
module cic_decimator_mc #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int RMAX      = 8,
    parameter int M         = 1,
    parameter int N         = 3,
    parameter int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N),
    parameter int OUT_WIDTH = WIDTH,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int RATE_W   = $clog2(RMAX + 1),
    localparam int SHIFT_W  = $clog2(REG_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    cic_decimator_mc_if.slave   axis,
    input  logic [RATE_W-1:0]   rate,
    input  logic [SHIFT_W-1:0]  shift,
    output logic                overflow
);
    typedef logic signed [REG_WIDTH-1:0] acc_t;

    localparam logic [RATE_W-1:0]  RATE_ONE  = RATE_W'(1);
    localparam logic [RATE_W-1:0]  RATE_MAX  = RATE_W'(RMAX);
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(REG_WIDTH - 1);
    localparam acc_t OUT_MAX = acc_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam acc_t OUT_MIN = acc_t'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    acc_t int_q [CHANNELS][N];
    acc_t int_d [CHANNELS][N];
    acc_t dly_q [CHANNELS][N][M];
    acc_t dly_d [CHANNELS][N][M];

    logic [CW-1:0]        chan_cnt_q, chan_cnt_d;
    logic [RATE_W-1:0]    phase_cnt_q, phase_cnt_d;
    logic [RATE_W-1:0]    rate_reg_q, rate_reg_d;
    logic [SHIFT_W-1:0]   shift_reg_q, shift_reg_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]        out_chan_q, out_chan_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overflow_q, overflow_d;

    logic                 in_ready, accept, latch, decim;
    logic [RATE_W-1:0]    rate_sel, rate_eff;
    logic [SHIFT_W-1:0]   shift_sel, shift_eff;
    acc_t                 in_ext, comb_x, scaled;

    // A decimating sample may only be taken when the output register can accept it.
    always_comb begin
        in_ready = (phase_cnt_q != '0) | !out_valid_q | axis.output_tready;
        accept   = axis.input_tvalid & in_ready;
        decim    = accept & (phase_cnt_q == '0);
        latch    = decim & (chan_cnt_q == '0);

        rate_sel = rate;
        if (rate == '0) begin
            rate_sel = RATE_ONE;
        end else if (rate > RATE_MAX) begin
            rate_sel = RATE_MAX;
        end
        shift_sel = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;

        rate_eff  = latch ? rate_sel : rate_reg_q;
        shift_eff = latch ? shift_sel : shift_reg_q;
    end

    always_comb begin
        int_d       = int_q;
        dly_d       = dly_q;
        chan_cnt_d  = chan_cnt_q;
        phase_cnt_d = phase_cnt_q;
        rate_reg_d  = rate_reg_q;
        shift_reg_d = shift_reg_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        in_ext      = acc_t'($signed(axis.input_tdata));
        comb_x      = '0;

        if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_cnt_q == CW'(c)) begin
                    int_d[c][0] = int_q[c][0] + in_ext;
                    for (int k = 1; k < N; k++) begin
                        int_d[c][k] = int_q[c][k] + int_q[c][k-1];
                    end
                    // Combs consume the integrator output as it stood before this sample.
                    if (decim) begin
                        comb_x = int_q[c][N-1];
                        for (int k = 0; k < N; k++) begin
                            for (int j = M - 1; j > 0; j--) begin
                                dly_d[c][k][j] = dly_q[c][k][j-1];
                            end
                            dly_d[c][k][0] = comb_x;
                            comb_x = comb_x - dly_q[c][k][M-1];
                        end
                    end
                end
            end

            if (latch) begin
                rate_reg_d  = rate_sel;
                shift_reg_d = shift_sel;
            end

            if (chan_cnt_q == CW'(CHANNELS - 1)) begin
                chan_cnt_d  = '0;
                phase_cnt_d = (phase_cnt_q == rate_eff - RATE_ONE) ? '0 : phase_cnt_q + RATE_ONE;
            end else begin
                chan_cnt_d = chan_cnt_q + CW'(1);
            end
        end

        scaled = comb_x >>> shift_eff;

        if (decim) begin
            out_valid_d = 1'b1;
            out_chan_d  = chan_cnt_q;
            if (scaled > OUT_MAX) begin
                out_data_d = OUT_MAX[OUT_WIDTH-1:0];
                overflow_d = 1'b1;
            end else if (scaled < OUT_MIN) begin
                out_data_d = OUT_MIN[OUT_WIDTH-1:0];
                overflow_d = 1'b1;
            end else begin
                out_data_d = scaled[OUT_WIDTH-1:0];
            end
        end else if (axis.output_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_q       <= '{default: '0};
            dly_q       <= '{default: '0};
            chan_cnt_q  <= '0;
            phase_cnt_q <= '0;
            rate_reg_q  <= RATE_ONE;
            shift_reg_q <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            int_q       <= int_d;
            dly_q       <= dly_d;
            chan_cnt_q  <= chan_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            rate_reg_q  <= rate_reg_d;
            shift_reg_q <= shift_reg_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign axis.input_tready  = in_ready;
    assign axis.output_tdata  = out_data_q;
    assign axis.output_tchan  = out_chan_q;
    assign axis.output_tvalid = out_valid_q;
    assign overflow           = overflow_q;
endmodule

// File: doc/cic_decimator_mc.md
Name: cic_decimator_mc

Overview:
- Multi-channel, time-interleaved CIC decimator: successor to the single-channel CIC decimator in the DSP library.
- Adds CHANNELS-way round-robin channel interleaving, per-channel integrator/comb state, and a registered output stage.
- Rate and shift are runtime-selectable and latched per decimation group; output uses arithmetic-shift gain normalisation with saturation to OUT_WIDTH.
- Sits between a multi-channel ADC/front-end stream and downstream FIR compensation; AXI-stream style in and out.

Parameters:
- WIDTH, 16, input sample width (signed two's complement)
- CHANNELS, 2, number of interleaved channels (>=1)
- RMAX, 8, maximum decimation rate
- M, 1, comb differential delay (>=1)
- N, 3, number of integrator and comb stages (>=1)
- REG_WIDTH, WIDTH+$clog2((RMAX*M)**N), internal accumulator width
- OUT_WIDTH, WIDTH, output sample width
- CW, (CHANNELS>1)?$clog2(CHANNELS):1, channel index width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- input_tdata  in  WIDTH  input sample for the current channel
- input_tvalid  in  1  input sample valid
- input_tready  out  1  input accept
- output_tdata  out  OUT_WIDTH  scaled, saturated decimated sample
- output_tchan  out  CW  channel index of output_tdata
- output_tvalid  out  1  output valid
- output_tready  in  1  downstream accept
- rate  in  $clog2(RMAX+1)  requested decimation rate
- shift  in  $clog2(REG_WIDTH)  output right-shift amount
- overflow  out  1  sticky flag; set on any saturation; cleared only by rst

Behaviour:
- Reset is asynchronous and active-high. rst clears all integrators, delay lines, combs, chan_cnt, phase_cnt, rate_reg=1, shift_reg=0, output_tvalid=0, output_tdata=0, output_tchan=0, overflow=0.
- Input order is strictly round-robin: channel 0,1,..,CHANNELS-1,0,...
  - Internal chan_cnt identifies each accepted sample's channel.
  - phase_cnt (0..rate_reg-1) advances when the channel CHANNELS-1 sample is accepted; it wraps to 0 at rate_reg-1.
- Latching: rate and shift are sampled into rate_reg and shift_reg on acceptance of a sample with chan_cnt=0 and phase_cnt=0.
  - rate 0 is treated as 1; rate>RMAX is clamped to RMAX.
  - shift>REG_WIDTH-1 is clamped to REG_WIDTH-1.
  - Changes mid-group take effect only at the next group boundary.
- Integrators, on accept of channel c:
  - int[c][0] += sext(input_tdata)
  - int[c][k] += old int[c][k-1] for k>=1
  - All stages update in the same cycle using pre-update values.
  - Arithmetic is modulo 2^REG_WIDTH; wrap is required and is not an error.
- Decimation: an accepted sample with phase_cnt=0 is a decimating sample. For channel c:
  - The comb chain runs once on the pre-update int[c][N-1].
  - comb[c][k] = x - delay[c][k][M-1], where x is the previous stage output.
  - The delay line shifts by one.
  - All arithmetic is mod 2^REG_WIDTH.
- Output formatting:
  - y = comb[c][N-1] >>> shift_reg (arithmetic shift).
  - If y is outside the signed OUT_WIDTH range, saturate to +max or -min and set overflow.
  - Register y into output_tdata and c into output_tchan; assert output_tvalid in the next cycle (latency 1 clock from accept).
- Handshake:
  - output_tvalid is cleared on output_tvalid&output_tready unless a new result loads in the same cycle; a simultaneous drain and load keeps valid high with the new data.
  - input_tready = (phase_cnt!=0) | !output_tvalid | output_tready. Non-decimating samples are never stalled.
  - output_tdata and output_tchan are held stable while output_tvalid & !output_tready.
- No sample is dropped or duplicated under any backpressure pattern.
- Reset asserted mid-stream discards in-flight state. The first sample after release is channel 0, phase 0.

Test Plan:
- CHANNELS=2, N=3, M=1, RMAX=8; ch0=+1, ch1=-2 constant; rate=4, shift=0 -> from the 4th output per channel: ch0=64, ch1=-128; output_tchan alternates 0,1; overflow=0.
- Same stimulus with shift=6 -> steady state ch0=1, ch1=-2; with rate=1, shift=0 -> every input reproduced on the next cycle, one output per sample.
- ch0=32767 constant, rate=8, shift=0 -> steady output 32767 (saturated) and overflow=1 sticky; shift=9 (new run after rst) -> 32766..32767 band, overflow=0.
- Hold output_tready=0 for 20 cycles mid-stream -> input_tready low only when phase_cnt=0 and output is full; output data held stable; after release the output sequence is identical to the no-stall run.
- Change rate 4->2 in the middle of a group -> current group completes at 4 samples per channel; the next group uses 2; rate=0 behaves as 1; rate=15 behaves as 8.
- Assert rst asynchronously (between clock edges) mid-group -> outputs 0 and output_tvalid=0 immediately; after release, the first output equals a fresh-start run.
